// File: rtl/router_egress_if.sv
// Bundle of FIFO-side and pin-side signals for the egress serializer.
// Handshake: a beat moves on any rising edge where out_vld && out_rdy; out_vld never waits on out_rdy.
interface router_egress_if #(
  parameter int WIDTH     = 64,
  parameter int OUT_WIDTH = 16
);
  logic                 empty;
  logic [WIDTH-1:0]     data_in;
  logic                 pop;
  logic                 out_vld;
  logic                 out_rdy;
  logic [OUT_WIDTH-1:0] out_data;
  logic                 out_first;
  logic                 out_last;
  logic                 out_par;

  modport master (
    output empty, data_in, out_rdy,
    input  pop, out_vld, out_data, out_first, out_last, out_par
  );

  modport slave (
    input  empty, data_in, out_rdy,
    output pop, out_vld, out_data, out_first, out_last, out_par
  );
endinterface

// File: rtl/router_egress.sv
// Pops 64-bit words from a first-word-fall-through FIFO and streams them as
// LSB-first beats with first/last markers, even parity and a sent-word counter.
module router_egress #(
  parameter int WIDTH     = 64,
  parameter int OUT_WIDTH = 16
) (
  input  logic          clk,
  input  logic          reset,
  router_egress_if.slave bus,
  output logic [15:0]   word_cnt,
  output logic          idle
);
  localparam int BEATS = WIDTH / OUT_WIDTH;
  localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [BW-1:0] LAST = BW'(BEATS - 1);

  typedef enum logic {IDLE, SEND} state_t;

  state_t               state, state_d;
  logic [WIDTH-1:0]     shreg, shreg_d;
  logic [BW-1:0]        beat, beat_d;
  logic [15:0]          cnt_q, cnt_d;
  logic                 xfer;
  logic                 last_beat;
  logic                 pop_i;
  logic [OUT_WIDTH-1:0] slice;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      shreg <= '0;
      beat  <= '0;
      cnt_q <= '0;
    end else begin
      state <= state_d;
      shreg <= shreg_d;
      beat  <= beat_d;
      cnt_q <= cnt_d;
    end
  end

  // Popping on the last accepted beat reloads the register in the same edge,
  // so consecutive words leave no gap in out_vld.
  always_comb begin
    last_beat = (beat == LAST);
    xfer      = (state == SEND) && bus.out_rdy;
    pop_i     = !reset && !bus.empty && ((state == IDLE) || (xfer && last_beat));
    state_d   = state;
    shreg_d   = shreg;
    beat_d    = beat;
    cnt_d     = cnt_q;
    case (state)
      IDLE: begin
        if (pop_i) begin
          shreg_d = bus.data_in;
          beat_d  = '0;
          state_d = SEND;
        end
      end
      SEND: begin
        if (xfer) begin
          if (!last_beat) begin
            beat_d = beat + 1'b1;
          end else begin
            cnt_d = cnt_q + 16'd1;
            if (pop_i) begin
              shreg_d = bus.data_in;
              beat_d  = '0;
            end else begin
              state_d = IDLE;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    slice = '0;
    if (state == SEND) slice = shreg[int'(beat) * OUT_WIDTH +: OUT_WIDTH];
    bus.pop       = pop_i;
    bus.out_vld   = (state == SEND);
    bus.out_data  = slice;
    bus.out_first = (state == SEND) && (beat == '0);
    bus.out_last  = (state == SEND) && last_beat;
    bus.out_par   = ^slice;
    word_cnt      = cnt_q;
    idle          = (state == IDLE) && bus.empty;
  end
endmodule
